// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared definitions for the LC-3 memory controller.
//   - MMIO register addresses (KBSR, KBDR, DSR, DDR, MCR)
//   - owner state encoding (HOST, CPU, DRAIN)
//   - MCR reset value and MMIO page decode helper
package lc3_mem_pkg;

   typedef enum logic [1:0] {
      OWN_HOST  = 2'd0,
      OWN_CPU   = 2'd1,
      OWN_DRAIN = 2'd2
   } owner_t;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

   localparam logic [15:0] MCR_RESET = 16'h8000;
   localparam logic [6:0]  MMIO_PAGE = 7'h7F;

   // FE00-FFFF is the I/O page
   function automatic logic is_mmio(input logic [15:0] addr);
      return addr[15:9] == MMIO_PAGE;
   endfunction

endpackage

// File: rtl/lc3_spram_bank.sv
// lc3_spram_bank: one 2^AW x 16 single-port RAM bank, 1-cycle registered read.
//   Clock  in   system clock
//   addr   in   word address within the bank
//   wdata  in   write data
//   we     in   write enable (write commits at the rising edge)
//   rdata  out  data at addr of the previous cycle (old data on a write cycle)
// Build macro SIM_FPGA: wraps the iCE40 SB_SPRAM256KA primitive instead of the
// behavioural array. Contents are never reset.
module lc3_spram_bank #(
   parameter int AW = 14
) (
   input  logic          Clock,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   input  logic          we,
   output logic [15:0]   rdata
);

`ifdef SIM_FPGA
   SB_SPRAM256KA u_spram (
      .ADDRESS    (addr),
      .DATAIN     (wdata),
      .MASKWREN   (4'b1111),
      .WREN       (we),
      .CHIPSELECT (1'b1),
      .CLOCK      (Clock),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (rdata)
   );
`else
   logic [15:0] mem [0:(1<<AW)-1];

   always_ff @(posedge Clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
`endif

endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: arbitrates four SPRAM banks (64K-word LC-3 space) between the
// program interface (host) and the LC-3 core, and decodes the I/O page.
//   Clock, reset                 rising-edge clock, synchronous active-high reset
//   cpu_run                      program interface starting/running
//   host_addr/wdata/we/rdata     host port; rdata is 1-cycle registered
//   host_conflict                pulse: host write dropped while CPU owns memory
//   cpu_req/we/addr/wdata        CPU request; accepted when cpu_req & cpu_ready
//   cpu_ready/rvalid/rdata       read data returns 1 cycle after accept
//   running                      CPU owns memory and MCR[15] set
//   kb_valid/data/ready          keyboard byte handshake into KBSR/KBDR
//   dsp_valid/data/ready         display byte handshake out of DDR
// Build macro LC3_MMIO_EN: enables KBSR/KBDR/DSR/DDR/MCR decode at FE00-FFFF.
// Without it the I/O page is plain RAM, kb_ready/dsp_valid stay 0, and running
// follows ownership alone.
//
// state     | meaning
// OWN_HOST  | host drives SPRAM, CPU stalled (cpu_ready = 0)
// OWN_CPU   | CPU drives SPRAM, host writes dropped
// OWN_DRAIN | one cycle after cpu_run falls so a last read can return
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int BANKS   = 4,
   parameter int BANK_AW = 14
) (
   input  logic        Clock,
   input  logic        reset,
   input  logic        cpu_run,
   input  logic [15:0] host_addr,
   input  logic [15:0] host_wdata,
   input  logic        host_we,
   output logic [15:0] host_rdata,
   output logic        host_conflict,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ready,
   output logic        cpu_rvalid,
   output logic [15:0] cpu_rdata,
   output logic        running,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   output logic        kb_ready,
   output logic        dsp_valid,
   output logic [7:0]  dsp_data,
   input  logic        dsp_ready
);

   localparam int BSW = 16 - BANK_AW;

   owner_t         owner;
   logic           host_side;
   logic           accept;
   logic           cpu_mmio;
   logic [15:0]    ram_addr;
   logic [15:0]    ram_wdata;
   logic           ram_we;
   logic [BSW-1:0] ram_bank;
   logic [15:0]    bank_rdata [BANKS];
   logic [BSW-1:0] rd_bank_q;
   logic [BSW-1:0] host_bank_q;
   logic           rd_mmio_q;
   logic           host_sel_q;
   logic [15:0]    mmio_rdata_q;

   assign host_side = (owner == OWN_HOST);
   assign cpu_ready = (owner == OWN_CPU);
   assign accept    = cpu_req & cpu_ready;

   // In DRAIN the CPU side still addresses the RAM but nothing is accepted
   assign ram_addr  = host_side ? host_addr  : cpu_addr;
   assign ram_wdata = host_side ? host_wdata : cpu_wdata;
   assign ram_we    = host_side ? host_we    : (accept & cpu_we & ~cpu_mmio);
   assign ram_bank  = ram_addr[15:BANK_AW];

   for (genvar i = 0; i < BANKS; i++) begin : g_bank
      lc3_spram_bank #(.AW(BANK_AW)) u_bank (
         .Clock (Clock),
         .addr  (ram_addr[BANK_AW-1:0]),
         .wdata (ram_wdata),
         .we    (ram_we && (ram_bank == BSW'(i))),
         .rdata (bank_rdata[i])
      );
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         owner         <= OWN_HOST;
         cpu_rvalid    <= 1'b0;
         rd_mmio_q     <= 1'b0;
         rd_bank_q     <= '0;
         host_sel_q    <= 1'b0;
         host_bank_q   <= '0;
         host_conflict <= 1'b0;
      end else begin
         case (owner)
            OWN_HOST:  if (cpu_run)  owner <= OWN_CPU;
            OWN_CPU:   if (!cpu_run) owner <= OWN_DRAIN;
            default:   owner <= OWN_HOST;
         endcase
         cpu_rvalid    <= accept & ~cpu_we;
         // read mux follows the bank captured at issue, not the live address
         rd_mmio_q     <= cpu_mmio;
         rd_bank_q     <= cpu_addr[15:BANK_AW];
         host_sel_q    <= host_side;
         host_bank_q   <= host_addr[15:BANK_AW];
         host_conflict <= host_we & ~host_side;
      end
   end

   assign cpu_rdata  = !cpu_rvalid ? 16'h0000 :
                       rd_mmio_q   ? mmio_rdata_q : bank_rdata[rd_bank_q];
   assign host_rdata = host_sel_q ? bank_rdata[host_bank_q] : 16'h0000;

`ifdef LC3_MMIO_EN
   logic [15:0] mcr;
   logic        kb_full;
   logic [7:0]  kb_byte;
   logic        dsp_valid_q;
   logic [7:0]  dsp_data_q;
   logic [15:0] mmio_rd;
   logic        mmio_acc;

   assign cpu_mmio = is_mmio(cpu_addr);
   assign mmio_acc = accept & cpu_mmio;

   always_comb begin
      mmio_rd = 16'h0000;
      case (cpu_addr)
         ADDR_KBSR: mmio_rd = {kb_full, 15'b0};
         ADDR_KBDR: mmio_rd = {8'b0, kb_byte};
         ADDR_DSR:  mmio_rd = {~dsp_valid_q, 15'b0};
         ADDR_MCR:  mmio_rd = mcr;
         default:   mmio_rd = 16'h0000;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         mcr          <= MCR_RESET;
         kb_full      <= 1'b0;
         kb_byte      <= 8'h00;
         dsp_valid_q  <= 1'b0;
         dsp_data_q   <= 8'h00;
         mmio_rdata_q <= 16'h0000;
      end else begin
         if (host_side && cpu_run)
            mcr <= MCR_RESET;
         else if (mmio_acc && cpu_we && cpu_addr == ADDR_MCR)
            mcr <= cpu_wdata;

         // KBDR read clears first; kb_ready is already low while full
         if (mmio_acc && !cpu_we && cpu_addr == ADDR_KBDR)
            kb_full <= 1'b0;
         else if (kb_valid && !kb_full) begin
            kb_full <= 1'b1;
            kb_byte <= kb_data;
         end

         if (dsp_valid_q && dsp_ready)
            dsp_valid_q <= 1'b0;
         else if (mmio_acc && cpu_we && cpu_addr == ADDR_DDR && !dsp_valid_q) begin
            dsp_valid_q <= 1'b1;
            dsp_data_q  <= cpu_wdata[7:0];
         end

         if (mmio_acc && !cpu_we) mmio_rdata_q <= mmio_rd;
      end
   end

   assign kb_ready  = ~kb_full;
   assign dsp_valid = dsp_valid_q;
   assign dsp_data  = dsp_data_q;
   assign running   = cpu_ready & mcr[15];
`else
   logic unused_io;

   assign cpu_mmio     = 1'b0;
   assign mmio_rdata_q = 16'h0000;
   assign kb_ready     = 1'b0;
   assign dsp_valid    = 1'b0;
   assign dsp_data     = 8'h00;
   assign running      = cpu_ready;
   assign unused_io    = ^{kb_valid, kb_data, dsp_ready};
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
module tb_lc3_mem_ctrl;

   logic        Clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_run = 1'b0;
   logic [15:0] host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic        host_we = 1'b0;
   logic [15:0] host_rdata;
   logic        host_conflict;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic        cpu_ready;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        running;
   logic        kb_valid = 1'b0;
   logic [7:0]  kb_data = '0;
   logic        kb_ready;
   logic        dsp_valid;
   logic [7:0]  dsp_data;
   logic        dsp_ready = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q [$];

`ifdef LC3_MMIO_EN
   localparam logic        KB_READY_IDLE = 1'b1;
   localparam logic [15:0] FE06_HOST_VAL = 16'h5A5A;
`else
   localparam logic        KB_READY_IDLE = 1'b0;
   localparam logic [15:0] FE06_HOST_VAL = 16'h1234;
`endif

   always #5 Clock = ~Clock;

   lc3_mem_ctrl dut (
      .Clock(Clock), .reset(reset), .cpu_run(cpu_run),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
      .host_rdata(host_rdata), .host_conflict(host_conflict),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .running(running),
      .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
      .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready)
   );

   // scoreboard: every cpu_rvalid pops the oldest expected read
   always @(negedge Clock) begin
      if (cpu_rvalid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL cpu_rvalid_unexpected got rdata=%h, nothing outstanding", cpu_rdata);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (cpu_rdata !== e) begin
               failures++;
               $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge Clock); host_addr = a; host_wdata = d; host_we = 1'b1;
      @(negedge Clock); host_we = 1'b0;
   endtask

   task automatic cpu_rd(input logic [15:0] a, input logic [15:0] e);
      @(negedge Clock); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; exp_q.push_back(e);
      @(negedge Clock); cpu_req = 1'b0;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge Clock); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      @(negedge Clock); cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge Clock);
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); end
      checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL reset_cpu_rvalid got=%b exp=0", cpu_rvalid); end
      checks++; if (host_conflict !== 1'b0) begin failures++; $display("FAIL reset_host_conflict got=%b exp=0", host_conflict); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
      checks++; if (dsp_valid !== 1'b0) begin failures++; $display("FAIL reset_dsp_valid got=%b exp=0", dsp_valid); end
      checks++; if (cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0000", cpu_rdata); end
      checks++; if (host_rdata !== 16'h0) begin failures++; $display("FAIL reset_host_rdata got=%h exp=0000", host_rdata); end
      checks++; if (dsp_data !== 8'h0) begin failures++; $display("FAIL reset_dsp_data got=%h exp=00", dsp_data); end
      checks++; if (kb_ready !== KB_READY_IDLE) begin failures++; $display("FAIL reset_kb_ready got=%b exp=%b", kb_ready, KB_READY_IDLE); end
      reset = 1'b0;
   endtask

   task automatic test_host;
      logic [15:0] ta [8] = '{16'h3000, 16'h3FFF, 16'h7FFF, 16'h3001,
                              16'h3002, 16'h8123, 16'hC456, 16'hFE06};
      logic [15:0] td [8] = '{16'hBEEF, 16'h1111, 16'h2222, 16'hCAFE,
                              16'h0102, 16'h3333, 16'h4444, 16'h5A5A};
      for (int i = 0; i < 8; i++) host_wr(ta[i], td[i]);
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock); host_addr = ta[i];
         @(negedge Clock);
         checks++;
         if (host_rdata !== td[i]) begin
            failures++; $display("FAIL host_read addr=%h got=%h exp=%h", ta[i], host_rdata, td[i]);
         end
      end
   endtask

   task automatic test_handover;
      @(negedge Clock); cpu_run = 1'b1;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL handover_ready_early got=%b exp=0", cpu_ready); end
      @(negedge Clock);
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL handover_ready got=%b exp=1", cpu_ready); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL handover_running got=%b exp=1", running); end
      cpu_rd(16'h3000, 16'hBEEF);
      @(negedge Clock); host_addr = 16'h3000; host_wdata = 16'hDEAD; host_we = 1'b1;
      @(negedge Clock); host_we = 1'b0;
      checks++; if (host_conflict !== 1'b1) begin failures++; $display("FAIL conflict_pulse got=%b exp=1", host_conflict); end
      @(negedge Clock);
      checks++; if (host_conflict !== 1'b0) begin failures++; $display("FAIL conflict_single got=%b exp=0", host_conflict); end
      cpu_rd(16'h3000, 16'hBEEF);
   endtask

   task automatic test_back_to_back;
      logic [15:0] ra [5] = '{16'h3001, 16'h3FFF, 16'h7FFF, 16'h8123, 16'hC456};
      logic [15:0] rd [5] = '{16'hCAFE, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ra[i]; exp_q.push_back(rd[i]);
      end
      @(negedge Clock); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 16'h0ABC;
      @(negedge Clock); cpu_we = 1'b0; exp_q.push_back(16'h0ABC);
      @(negedge Clock); cpu_req = 1'b0;
   endtask

`ifdef LC3_MMIO_EN
   task automatic test_keyboard;
      @(negedge Clock); kb_valid = 1'b1; kb_data = 8'h41;
      checks++; if (kb_ready !== 1'b1) begin failures++; $display("FAIL kb_ready_empty got=%b exp=1", kb_ready); end
      @(negedge Clock); kb_valid = 1'b0;
      checks++; if (kb_ready !== 1'b0) begin failures++; $display("FAIL kb_ready_full got=%b exp=0", kb_ready); end
      cpu_rd(16'hFE00, 16'h8000);
      cpu_rd(16'hFE02, 16'h0041);
      checks++; if (kb_ready !== 1'b1) begin failures++; $display("FAIL kb_ready_after_read got=%b exp=1", kb_ready); end
      cpu_rd(16'hFE00, 16'h0000);
      // KBDR read colliding with a new offered byte
      @(negedge Clock); kb_valid = 1'b1; kb_data = 8'h42;
      @(negedge Clock); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFE02; kb_data = 8'h43;
      exp_q.push_back(16'h0042);
      checks++; if (kb_ready !== 1'b0) begin failures++; $display("FAIL kb_ready_collide got=%b exp=0", kb_ready); end
      @(negedge Clock); cpu_req = 1'b0;
      checks++; if (kb_ready !== 1'b1) begin failures++; $display("FAIL kb_ready_post_clear got=%b exp=1", kb_ready); end
      @(negedge Clock); kb_valid = 1'b0;
      cpu_rd(16'hFE02, 16'h0043);
   endtask

   task automatic test_display;
      cpu_wr(16'hFE06, 16'h0048);
      checks++; if (dsp_valid !== 1'b1) begin failures++; $display("FAIL dsp_valid_set got=%b exp=1", dsp_valid); end
      checks++; if (dsp_data !== 8'h48) begin failures++; $display("FAIL dsp_data got=%h exp=48", dsp_data); end
      cpu_rd(16'hFE04, 16'h0000);
      cpu_wr(16'hFE06, 16'h0049);
      checks++; if (dsp_data !== 8'h48) begin failures++; $display("FAIL dsp_data_held got=%h exp=48", dsp_data); end
      @(negedge Clock); dsp_ready = 1'b1;
      @(negedge Clock); dsp_ready = 1'b0;
      checks++; if (dsp_valid !== 1'b0) begin failures++; $display("FAIL dsp_valid_clear got=%b exp=0", dsp_valid); end
      cpu_rd(16'hFE04, 16'h8000);
      cpu_rd(16'hFFFE, 16'h8000);
      cpu_wr(16'hFE10, 16'hFFFF);
      cpu_rd(16'hFE10, 16'h0000);
   endtask

   task automatic test_halt;
      cpu_wr(16'hFFFE, 16'h0000);
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL halt_running got=%b exp=0", running); end
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL halt_ready got=%b exp=1", cpu_ready); end
      cpu_rd(16'hFFFE, 16'h0000);
   endtask
`else
   task automatic test_no_mmio;
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL plain_running got=%b exp=1", running); end
      cpu_wr(16'hFE06, 16'h1234);
      checks++; if (dsp_valid !== 1'b0) begin failures++; $display("FAIL plain_dsp_valid got=%b exp=0", dsp_valid); end
      cpu_rd(16'hFE06, 16'h1234);
      @(negedge Clock); kb_valid = 1'b1; kb_data = 8'h41;
      checks++; if (kb_ready !== 1'b0) begin failures++; $display("FAIL plain_kb_ready got=%b exp=0", kb_ready); end
      @(negedge Clock); kb_valid = 1'b0;
   endtask
`endif

   task automatic test_drain;
      @(negedge Clock); cpu_run = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
      exp_q.push_back(16'hBEEF);
      @(negedge Clock); cpu_req = 1'b0;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL drain_ready got=%b exp=0", cpu_ready); end
      host_addr = 16'h3002; host_wdata = 16'h7777; host_we = 1'b1;
      @(negedge Clock); host_we = 1'b0;
      checks++; if (host_conflict !== 1'b1) begin failures++; $display("FAIL drain_conflict got=%b exp=1", host_conflict); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL drain_running got=%b exp=0", running); end
      @(negedge Clock); host_addr = 16'h3002;
      @(negedge Clock);
      checks++; if (host_rdata !== 16'h0102) begin failures++; $display("FAIL drain_ram_kept got=%h exp=0102", host_rdata); end
      host_addr = 16'hFE06;
      @(negedge Clock);
      checks++; if (host_rdata !== FE06_HOST_VAL) begin failures++; $display("FAIL host_fe06 got=%h exp=%h", host_rdata, FE06_HOST_VAL); end
      host_wr(16'h3002, 16'h0505);
      @(negedge Clock); host_addr = 16'h3002;
      @(negedge Clock);
      checks++; if (host_rdata !== 16'h0505) begin failures++; $display("FAIL host_back got=%h exp=0505", host_rdata); end
   endtask

   task automatic test_reset_mid;
      @(negedge Clock); cpu_run = 1'b1;
      @(negedge Clock);
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL rerun_running got=%b exp=1", running); end
`ifdef LC3_MMIO_EN
      kb_valid = 1'b1; kb_data = 8'h55;
      @(negedge Clock); kb_valid = 1'b0;
      cpu_wr(16'hFE06, 16'h0021);
      checks++; if (dsp_valid !== 1'b1) begin failures++; $display("FAIL mid_dsp_valid got=%b exp=1", dsp_valid); end
`endif
      @(negedge Clock); reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
      @(negedge Clock); cpu_req = 1'b0;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", cpu_ready); end
      checks++; if (kb_ready !== KB_READY_IDLE) begin failures++; $display("FAIL mid_reset_kb_ready got=%b exp=%b", kb_ready, KB_READY_IDLE); end
      checks++; if (dsp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_dsp_valid got=%b exp=0", dsp_valid); end
      checks++; if (dsp_data !== 8'h00) begin failures++; $display("FAIL mid_reset_dsp_data got=%h exp=00", dsp_data); end
      reset = 1'b0; cpu_run = 1'b0;
      repeat (3) @(negedge Clock);
   endtask

   initial begin
      test_reset();
      test_host();
      test_handover();
      test_back_to_back();
`ifdef LC3_MMIO_EN
      test_keyboard();
      test_display();
      test_halt();
`else
      test_no_mmio();
`endif
      test_drain();
      test_reset_mid();
      repeat (3) @(negedge Clock);
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL reads_outstanding got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
